mem_stage: RTL and testbench

- Memory-access stage of the multi-cycle core, between execute and write-back.
- Accepts one instruction from execute and issues at most one data-memory request with a req/ack handshake.
- Aligns, sign- or zero-extends load data.
- Presents ALU result, load data and control to write-back with a one-cycle valid pulse.

---
 rtl/mem_stage_if.sv | 64 ++++++
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Bus interfaces around the memory-access stage.
//   ex_mem_if : execute -> mem_stage instruction handoff (master = execute, slave = mem_stage)
//   dmem_if   : mem_stage -> data memory req/ack port   (master = mem_stage, slave = memory)
//   wb_if     : mem_stage -> write-back payload          (master = mem_stage, slave = write-back)
interface ex_mem_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  valid_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] alu_result_i;
    logic [DATA_WIDTH-1:0] store_data_i;
    logic                  is_load_i;
    logic                  is_store_i;
    logic [1:0]            size_i;
    logic                  unsigned_i;

    modport master (
        output valid_i, alu_result_i, store_data_i, is_load_i, is_store_i, size_i, unsigned_i,
        input  ready_o
    );
    modport slave (
        input  valid_i, alu_result_i, store_data_i, is_load_i, is_store_i, size_i, unsigned_i,
        output ready_o
    );
endinterface

interface dmem_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    dmem_req_o;
    logic                    dmem_we_o;
    logic [ADDR_WIDTH-1:0]   dmem_addr_o;
    logic [DATA_WIDTH/8-1:0] dmem_be_o;
    logic [DATA_WIDTH-1:0]   dmem_wdata_o;
    logic                    dmem_ack_i;
    logic [DATA_WIDTH-1:0]   dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i
    );
    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i
    );
endinterface

interface wb_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  wb_valid_o;
    logic [DATA_WIDTH-1:0] alu_result_o;
    logic [DATA_WIDTH-1:0] data_from_mem_o;
    logic                  is_load_o;
    logic                  is_store_o;

    modport master (
        output wb_valid_o, alu_result_o, data_from_mem_o, is_load_o, is_store_o
    );
    modport slave (
        input  wb_valid_o, alu_result_o, data_from_mem_o, is_load_o, is_store_o
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: accepts one instruction from execute, issues at most one
// data-memory request (req held until ack), aligns and extends load data, and
// hands the result to write-back with a one-cycle wb_valid_o pulse.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   ex   (slave)   instruction from execute (valid/ready)
//   dmem (master)  data-memory request port
//   wb   (master)  registered write-back payload
//   misalign_o     only with MEM_STAGE_MISALIGN_CHK_EN: misaligned access flagged with wb_valid_o
// Optional feature macro: MEM_STAGE_MISALIGN_CHK_EN (misaligned halves/words skip the
// memory access and are reported instead of being truncated).
module mem_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    ex_mem_if.slave  ex,
    dmem_if.master   dmem,
    wb_if.master     wb
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    ,
    output logic     misalign_o
`endif
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic            accept_c;
    logic            ack_c;
    logic [1:0]      off_c;
    logic            is_mem_c;
    logic            mis_c;
    logic [BE_W-1:0] be_c;
    logic [DATA_WIDTH-1:0] wdata_c;

    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            uns_q;

    logic [7:0]            byte_c;
    logic [15:0]           half_c;
    logic [DATA_WIDTH-1:0] ext_c;

    // Accept-time decode of the incoming instruction
    always_comb begin
        off_c    = ex.alu_result_i[1:0];
        is_mem_c = ex.is_load_i | ex.is_store_i;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        mis_c    = is_mem_c && (((ex.size_i == 2'b01) && off_c[0]) ||
                                (ex.size_i[1] && (off_c != 2'b00)));
`else
        mis_c    = 1'b0;
`endif
        // Lanes shifted past byte 3 fall off the 4-bit enable
        case (ex.size_i)
            2'b00:   be_c = BE_W'(4'b0001 << off_c);
            2'b01:   be_c = BE_W'(4'b0011 << off_c);
            default: be_c = {BE_W{1'b1}};
        endcase
        case (ex.size_i)
            2'b00:   wdata_c = {4{ex.store_data_i[7:0]}};
            2'b01:   wdata_c = {2{ex.store_data_i[15:0]}};
            default: wdata_c = ex.store_data_i;
        endcase
    end

    // Load data alignment and extension from the captured offset/size
    always_comb begin
        byte_c = 8'h00;
        half_c = 16'h0000;
        ext_c  = dmem.dmem_rdata_i;
        case (off_q)
            2'd0: begin
                byte_c = dmem.dmem_rdata_i[7:0];
                half_c = dmem.dmem_rdata_i[15:0];
            end
            2'd1: begin
                byte_c = dmem.dmem_rdata_i[15:8];
                half_c = dmem.dmem_rdata_i[23:8];
            end
            2'd2: begin
                byte_c = dmem.dmem_rdata_i[23:16];
                half_c = dmem.dmem_rdata_i[31:16];
            end
            default: begin
                byte_c = dmem.dmem_rdata_i[31:24];
                half_c = {8'h00, dmem.dmem_rdata_i[31:24]};
            end
        endcase
        case (size_q)
            2'b00:   ext_c = uns_q ? {{(DATA_WIDTH-8){1'b0}}, byte_c}
                                   : {{(DATA_WIDTH-8){byte_c[7]}}, byte_c};
            2'b01:   ext_c = uns_q ? {{(DATA_WIDTH-16){1'b0}}, half_c}
                                   : {{(DATA_WIDTH-16){half_c[15]}}, half_c};
            default: ext_c = dmem.dmem_rdata_i;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        ack_c     = 1'b0;
        case (state)
            IDLE: begin
                if (ex.valid_i) begin
                    accept_c  = 1'b1;
                    state_nxt = (is_mem_c && !mis_c) ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (dmem.dmem_ack_i) begin
                    ack_c     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs; handshake flags are decoded from the next state so they
    // line up with the state register and clear asynchronously on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex.ready_o         <= 1'b1;
            dmem.dmem_req_o    <= 1'b0;
            dmem.dmem_we_o     <= 1'b0;
            dmem.dmem_addr_o   <= '0;
            dmem.dmem_be_o     <= '0;
            dmem.dmem_wdata_o  <= '0;
            wb.wb_valid_o      <= 1'b0;
            wb.alu_result_o    <= '0;
            wb.data_from_mem_o <= '0;
            wb.is_load_o       <= 1'b0;
            wb.is_store_o      <= 1'b0;
            off_q              <= 2'b00;
            size_q             <= 2'b00;
            uns_q              <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_CHK_EN
            misalign_o         <= 1'b0;
`endif
        end else begin
            ex.ready_o      <= (state_nxt == IDLE);
            dmem.dmem_req_o <= (state_nxt == ACCESS);
            wb.wb_valid_o   <= (state_nxt == DONE);
`ifdef MEM_STAGE_MISALIGN_CHK_EN
            misalign_o      <= accept_c && mis_c;
`endif
            if (accept_c) begin
                wb.alu_result_o    <= ex.alu_result_i;
                wb.is_load_o       <= ex.is_load_i & ~mis_c;
                wb.is_store_o      <= ex.is_store_i & ~mis_c;
                wb.data_from_mem_o <= '0;
                dmem.dmem_addr_o   <= {ex.alu_result_i[ADDR_WIDTH-1:2], 2'b00};
                // Load+store collisions are serviced as loads
                dmem.dmem_we_o     <= ex.is_store_i & ~ex.is_load_i;
                dmem.dmem_be_o     <= be_c;
                dmem.dmem_wdata_o  <= wdata_c;
                off_q              <= off_c;
                size_q             <= ex.size_i;
                uns_q              <= ex.unsigned_i;
            end
            if (ack_c && wb.is_load_o) begin
                wb.data_from_mem_o <= ext_c;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_mem_if #(.DATA_WIDTH(32))                 ex ();
    dmem_if   #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dm ();
    wb_if     #(.DATA_WIDTH(32))                 wb ();
`ifdef MEM_STAGE_MISALIGN_CHK_EN
    logic misalign;
`endif

    mem_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .ex    (ex),
        .dmem  (dm),
        .wb    (wb)
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        ,
        .misalign_o (misalign)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;
        logic        e_mem;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[11];

    // Reference model: byte lanes as plain arithmetic over a 4-byte word
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input int off);
        logic [3:0] be;
        int n = nbytes(sz);
        for (int i = 0; i < 4; i++) be[i] = (n == 4) || (i >= off && i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        int n = nbytes(sz);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input int off,
                                           input logic [31:0] rdata);
        longint v = 0;
        int n = nbytes(sz);
        if (n == 4) return rdata;
        for (int k = 0; k < n; k++)
            if (off + k < 4) v += longint'(rdata[8*(off+k) +: 8]) << (8*k);
        if (!uns && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    function automatic logic m_misaligned(input logic mem, input logic [1:0] sz, input int off);
`ifdef MEM_STAGE_MISALIGN_CHK_EN
        return mem && ((sz == 2'b01 && (off % 2) == 1) || (sz[1] && off != 0));
`else
        return 1'b0 && mem && sz[0] && (off != 0);
`endif
    endfunction

    // One instruction: drive, service the memory port, check request and write-back
    task automatic run_op(input string name, input logic ld, input logic st, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int delay,
                          input logic e_mem, input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic e_we, input logic [31:0] e_wdata, input logic [31:0] e_data,
                          input logic e_ld, input logic e_st, input logic e_mis);
        int reqs = 0;
        int cyc  = 0;
        bit seen = 0;
        @(negedge clk);
        check($sformatf("%s ready_before", name), 32'(ex.ready_o), 32'd1);
        ex.valid_i = 1'b1; ex.is_load_i = ld; ex.is_store_i = st; ex.size_i = sz;
        ex.unsigned_i = uns; ex.alu_result_i = addr; ex.store_data_i = sdata;
        @(posedge clk);
        #1;
        ex.valid_i = 1'b0; ex.alu_result_i = $urandom; ex.store_data_i = $urandom;
        ex.size_i = 2'($urandom); ex.is_load_i = 1'($urandom); ex.is_store_i = 1'($urandom);
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            dm.dmem_ack_i = 1'b0;
            dm.dmem_rdata_i = $urandom;
            if (wb.wb_valid_o) begin
                seen = 1;
                check($sformatf("%s alu_result", name), wb.alu_result_o, addr);
                check($sformatf("%s data_from_mem", name), wb.data_from_mem_o, e_data);
                check($sformatf("%s is_load", name), 32'(wb.is_load_o), 32'(e_ld));
                check($sformatf("%s is_store", name), 32'(wb.is_store_o), 32'(e_st));
                check($sformatf("%s req_at_wb", name), 32'(dm.dmem_req_o), 32'd0);
`ifdef MEM_STAGE_MISALIGN_CHK_EN
                check($sformatf("%s misalign", name), 32'(misalign), 32'(e_mis));
`endif
            end else if (dm.dmem_req_o) begin
                reqs++;
                if (reqs == 1) begin
                    check($sformatf("%s addr", name), dm.dmem_addr_o, e_addr);
                    check($sformatf("%s be", name), 32'(dm.dmem_be_o), 32'(e_be));
                    check($sformatf("%s we", name), 32'(dm.dmem_we_o), 32'(e_we));
                    check($sformatf("%s wdata", name), dm.dmem_wdata_o, e_wdata);
                    check($sformatf("%s ready_busy", name), 32'(ex.ready_o), 32'd0);
                end
                if (reqs == delay + 1) begin
                    dm.dmem_ack_i = 1'b1;
                    dm.dmem_rdata_i = rdata;
                end
            end
        end
        dm.dmem_ack_i = 1'b0;
        check($sformatf("%s wb_seen", name), 32'(seen), 32'd1);
        check($sformatf("%s req_cycles", name), 32'(reqs), e_mem ? 32'(delay + 1) : 32'd0);
        check($sformatf("%s latency", name), 32'(cyc), e_mem ? 32'(delay + 2) : 32'd1);
        @(negedge clk);
        check($sformatf("%s wb_pulse_end", name), 32'(wb.wb_valid_o), 32'd0);
        check($sformatf("%s ready_after", name), 32'(ex.ready_o), 32'd1);
        if (e_mis === 1'b0 && e_ld === 1'b0 && e_st === 1'b0)
            check($sformatf("%s data_hold", name), wb.data_from_mem_o, 32'd0);
    endtask

    task automatic run_model(input string name, input logic ld, input logic st, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int delay);
        int   off = int'(addr[1:0]);
        logic mis = m_misaligned(ld | st, sz, off);
        logic mem = (ld | st) & ~mis;
        run_op(name, ld, st, sz, uns, addr, sdata, rdata, delay,
               mem, {addr[31:2], 2'b00}, m_be(sz, off), st & ~ld, m_wdata(sz, sdata),
               (mem && ld) ? m_load(sz, uns, off, rdata) : 32'd0,
               ld & ~mis, st & ~mis, mis);
    endtask

    initial begin
        int  cnt;
        bit  bad;
        vecs[0]  = '{"alu",   0, 0, 2'b10, 0, 32'h0000_1234, 32'h0,         32'h0,         0, 0, 32'h0,   4'h0,    0, 32'h0,         32'h0};
        vecs[1]  = '{"lw",    1, 0, 2'b10, 0, 32'h0000_0100, 32'h1111_2222, 32'hDEAD_BEEF, 3, 1, 32'h100, 4'b1111, 0, 32'h1111_2222, 32'hDEAD_BEEF};
        vecs[2]  = '{"lb",    1, 0, 2'b00, 0, 32'h0000_0103, 32'h0,         32'h8000_0000, 0, 1, 32'h100, 4'b1000, 0, 32'h0,         32'hFFFF_FF80};
        vecs[3]  = '{"lbu",   1, 0, 2'b00, 1, 32'h0000_0103, 32'h0,         32'h8000_0000, 0, 1, 32'h100, 4'b1000, 0, 32'h0,         32'h0000_0080};
        vecs[4]  = '{"sh",    0, 1, 2'b01, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,         1, 1, 32'h200, 4'b1100, 1, 32'hABCD_ABCD, 32'h0};
        vecs[5]  = '{"lh",    1, 0, 2'b01, 0, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 1, 32'h100, 4'b1100, 0, 32'h0,         32'hFFFF_8001};
        vecs[6]  = '{"lhu",   1, 0, 2'b01, 1, 32'h0000_0100, 32'h0,         32'h1234_F00F, 2, 1, 32'h100, 4'b0011, 0, 32'h0,         32'h0000_F00F};
        vecs[7]  = '{"sb",    0, 1, 2'b00, 0, 32'h0000_0101, 32'h0000_AB12, 32'h0,         2, 1, 32'h100, 4'b0010, 1, 32'h1212_1212, 32'h0};
        vecs[8]  = '{"sw",    0, 1, 2'b10, 0, 32'h0000_0304, 32'hCAFE_F00D, 32'h0,         0, 1, 32'h304, 4'b1111, 1, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{"ld_st", 1, 1, 2'b10, 0, 32'h0000_0108, 32'h0000_0055, 32'h0102_0304, 1, 1, 32'h108, 4'b1111, 0, 32'h0000_0055, 32'h0102_0304};
        vecs[10] = '{"lw_sz3",1, 0, 2'b11, 0, 32'h0000_010C, 32'h0,         32'h8765_4321, 0, 1, 32'h10C, 4'b1111, 0, 32'h0,         32'h8765_4321};

        ex.valid_i = 0; ex.alu_result_i = 0; ex.store_data_i = 0; ex.is_load_i = 0;
        ex.is_store_i = 0; ex.size_i = 0; ex.unsigned_i = 0;
        dm.dmem_ack_i = 0; dm.dmem_rdata_i = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst ready", 32'(ex.ready_o), 32'd1);
        check("rst req", 32'(dm.dmem_req_o), 32'd0);
        check("rst wb_valid", 32'(wb.wb_valid_o), 32'd0);
        check("rst alu_result", wb.alu_result_o, 32'd0);
        check("rst data", wb.data_from_mem_o, 32'd0);
        check("rst be", 32'(dm.dmem_be_o), 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++)
            run_op(vecs[i].name, vecs[i].ld, vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                   vecs[i].sdata, vecs[i].rdata, vecs[i].delay, vecs[i].e_mem, vecs[i].e_addr,
                   vecs[i].e_be, vecs[i].e_we, vecs[i].e_wdata, vecs[i].e_data,
                   vecs[i].ld, vecs[i].st, 1'b0);

        // Misaligned word: flagged when the check is built in, truncated otherwise
        run_model("lw_misaligned", 1, 0, 2'b10, 0, 32'h0000_0102, 32'h0, 32'h1357_9BDF, 0);
        run_model("lh_misaligned", 1, 0, 2'b01, 0, 32'h0000_0203, 32'h0, 32'h8A00_0000, 1);

        // Ack while idle is ignored
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            dm.dmem_ack_i = 1'b1;
            if (wb.wb_valid_o || dm.dmem_req_o) bad = 1;
        end
        @(negedge clk);
        dm.dmem_ack_i = 1'b0;
        if (wb.wb_valid_o || dm.dmem_req_o) bad = 1;
        check("idle_ack ignored", 32'(bad), 32'd0);

        // valid_i held high with a different instruction during ACCESS
        @(negedge clk);
        ex.valid_i = 1; ex.is_load_i = 1; ex.is_store_i = 0; ex.size_i = 2'b10;
        ex.unsigned_i = 0; ex.alu_result_i = 32'h100; ex.store_data_i = 0;
        @(posedge clk);
        #1;
        ex.is_load_i = 0; ex.alu_result_i = 32'h5555;
        cnt = 0; bad = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            dm.dmem_ack_i = 1'b0;
            if (wb.wb_valid_o) break;
            if (ex.ready_o) bad = 1;
            if (dm.dmem_req_o) begin
                cnt++;
                if (cnt == 3) begin dm.dmem_ack_i = 1'b1; dm.dmem_rdata_i = 32'hA5A5_A5A5; end
            end
        end
        dm.dmem_ack_i = 1'b0;
        check("hold wb_valid first", 32'(wb.wb_valid_o), 32'd1);
        check("hold not_ready", 32'(bad), 32'd0);
        check("hold alu first", wb.alu_result_o, 32'h100);
        check("hold data first", wb.data_from_mem_o, 32'hA5A5_A5A5);
        @(negedge clk);
        check("hold ready again", 32'(ex.ready_o), 32'd1);
        @(posedge clk);
        #1;
        ex.valid_i = 0;
        @(negedge clk);
        check("hold wb_valid second", 32'(wb.wb_valid_o), 32'd1);
        check("hold alu second", wb.alu_result_o, 32'h5555);
        check("hold data second", wb.data_from_mem_o, 32'd0);
        check("hold is_load second", 32'(wb.is_load_o), 32'd0);

        // Reset during ACCESS, then a stray ack
        @(negedge clk);
        ex.valid_i = 1; ex.is_load_i = 1; ex.is_store_i = 0; ex.size_i = 2'b10;
        ex.alu_result_i = 32'h200;
        @(posedge clk);
        #1;
        ex.valid_i = 0;
        @(negedge clk);
        check("rst_mid req_before", 32'(dm.dmem_req_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid req_drop", 32'(dm.dmem_req_o), 32'd0);
        check("rst_mid ready", 32'(ex.ready_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            dm.dmem_ack_i = 1'b1;
            @(negedge clk);
            if (wb.wb_valid_o || dm.dmem_req_o) bad = 1;
        end
        dm.dmem_ack_i = 1'b0;
        check("rst_mid late_ack", 32'(bad), 32'd0);

        // Randomized against the reference model
        for (int r = 0; r < 40; r++) begin
            logic [1:0] kind = 2'($urandom_range(0, 3));
            run_model($sformatf("rand%0d", r), kind[0], kind[1], 2'($urandom), 1'($urandom),
                      $urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
